// File: rtl/spi_sipo_deser_if.sv
// Output word port of the SPI receive deserialiser: the completed word plus its
// valid/ready handshake towards the RX FIFO / register file.
// Optional feature macro: SPI_SIPO_PARITY_EN adds the parity_err flag that
// travels with data_out.
interface spi_sipo_deser_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              out_ready;
`ifdef SPI_SIPO_PARITY_EN
  logic              parity_err;
`endif

  // Deserialiser side: produces the word, observes the consumer's ready
  modport master (
    output data_out,
    output out_valid,
`ifdef SPI_SIPO_PARITY_EN
    output parity_err,
`endif
    input  out_ready
  );

  // Consumer side: takes the word when out_valid && out_ready
  modport slave (
    input  data_out,
    input  out_valid,
`ifdef SPI_SIPO_PARITY_EN
    input  parity_err,
`endif
    output out_ready
  );
endinterface

// File: rtl/spi_sipo_deser.sv
// SPI receive deserialiser: shifts MISO bits in on shift_en, counts bits per
// frame and presents each completed DATA_W-bit word on a valid/ready port.
// A word that completes while the previous one is still unaccepted is dropped
// and the sticky overrun flag is raised; clr (CS deassert) restarts the frame.
// Optional feature macro: SPI_SIPO_PARITY_EN appends one even-parity bit to
// every frame (always the last bit) and reports the check in parity_err.
module spi_sipo_deser #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    shift_en,
  input  logic                    miso,
  spi_sipo_deser_if.master        out_if,
  output logic                    busy,
  output logic                    overrun
);

`ifdef SPI_SIPO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = DATA_W + PAR_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  // Insert one received bit at the end selected by the bit order.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sr,
                                                 input logic              bit_in);
    if (LSB_FIRST)
      return {bit_in, sr[DATA_W-1:1]};
    else
      return {sr[DATA_W-2:0], bit_in};
  endfunction

  // Stage p0: shift register and bit counter of the frame being received
  logic [DATA_W-1:0] sr_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic              busy_p0;

  // Stage p1: held output word and its status
  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  logic              ovr_p1;
`ifdef SPI_SIPO_PARITY_EN
  logic              perr_p1;
  logic              perr_nxt;
`endif

  logic [DATA_W-1:0] sr_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] word_nxt;
  logic              frame_last;
  logic              complete;
  logic              accept;
  logic              load;
  logic              drop;

  assign frame_last = (cnt_p0 == CNT_W'(FRAME_BITS - 1));

  // Next frame state, word assembly and output-register decisions
  always_comb begin
    sr_nxt   = sr_p0;
    cnt_nxt  = cnt_p0;
    complete = 1'b0;
`ifdef SPI_SIPO_PARITY_EN
    // The parity bit is never shifted into sr: the data word is already complete.
    word_nxt = sr_p0;
    perr_nxt = (^sr_p0) ^ miso;
`else
    // The final data bit is folded in directly so the word is ready one cycle later.
    word_nxt = shift_in(sr_p0, miso);
`endif
    if (clr) begin
      // CS deassert wins over a coincident shift: that bit is discarded.
      sr_nxt  = '0;
      cnt_nxt = '0;
    end else if (shift_en) begin
      complete = frame_last;
      cnt_nxt  = frame_last ? '0 : cnt_p0 + CNT_W'(1);
`ifdef SPI_SIPO_PARITY_EN
      if (cnt_p0 < CNT_W'(DATA_W))
        sr_nxt = shift_in(sr_p0, miso);
`else
      sr_nxt = shift_in(sr_p0, miso);
`endif
    end
    accept = vld_p1 && out_if.out_ready;
    // A new word may enter when the register is empty or is being emptied now.
    load   = complete && (!vld_p1 || out_if.out_ready);
    drop   = complete && vld_p1 && !out_if.out_ready;
  end

  // Stage p0 registers: frame shift register, bit counter, busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_p0   <= '0;
      cnt_p0  <= '0;
      busy_p0 <= 1'b0;
    end else begin
      sr_p0   <= sr_nxt;
      cnt_p0  <= cnt_nxt;
      busy_p0 <= (cnt_nxt != '0);
    end
  end

  // Stage p1 registers: held word, valid handshake, sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      ovr_p1  <= 1'b0;
`ifdef SPI_SIPO_PARITY_EN
      perr_p1 <= 1'b0;
`endif
    end else begin
      if (load) begin
        data_p1 <= word_nxt;
`ifdef SPI_SIPO_PARITY_EN
        perr_p1 <= perr_nxt;
`endif
      end
      if (load)
        vld_p1 <= 1'b1;
      else if (accept)
        vld_p1 <= 1'b0;
      // clr blocks completion, so a drop can never coincide with the clear.
      if (clr)
        ovr_p1 <= 1'b0;
      else if (drop)
        ovr_p1 <= 1'b1;
    end
  end

  assign out_if.data_out   = data_p1;
  assign out_if.out_valid  = vld_p1;
`ifdef SPI_SIPO_PARITY_EN
  assign out_if.parity_err = perr_p1;
`endif
  assign busy    = busy_p0;
  assign overrun = ovr_p1;

endmodule

// File: tb/tb_spi_sipo_deser.sv
// Scoreboard bench for spi_sipo_deser: one MSB-first and one LSB-first instance
// share the same serial stimulus; a bit-list reference model predicts every word,
// and negedge monitors pop and compare whenever a word is handed over.
// Optional feature macro: SPI_SIPO_PARITY_EN (bench follows the RTL build).
module tb_spi_sipo_deser;
  localparam int W = 8;
`ifdef SPI_SIPO_PARITY_EN
  localparam int FB = W + 1;
`else
  localparam int FB = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0, clr = 1'b0, shift_en = 1'b0, miso = 1'b0, ready = 1'b0;
  logic busy_m, ovr_m, busy_l, ovr_l;
  logic perr_m, perr_l;

  spi_sipo_deser_if #(.DATA_W(W)) if_m ();
  spi_sipo_deser_if #(.DATA_W(W)) if_l ();
  assign if_m.out_ready = ready;
  assign if_l.out_ready = ready;
`ifdef SPI_SIPO_PARITY_EN
  assign perr_m = if_m.parity_err;
  assign perr_l = if_l.parity_err;
`else
  assign perr_m = 1'b0;
  assign perr_l = 1'b0;
`endif

  spi_sipo_deser #(.DATA_W(W), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .clr(clr), .shift_en(shift_en), .miso(miso),
    .out_if(if_m), .busy(busy_m), .overrun(ovr_m));

  spi_sipo_deser #(.DATA_W(W), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .clr(clr), .shift_en(shift_en), .miso(miso),
    .out_if(if_l), .busy(busy_l), .overrun(ovr_l));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: received bits of the current frame kept as a plain list
  logic         frame_bits[$];
  logic         m_valid = 1'b0, m_ovr = 1'b0, m_busy = 1'b0;
  logic [W-1:0] m_data_m = '0, m_data_l = '0;
  logic         m_perr = 1'b0;
  logic [W:0]   exp_m[$];
  logic [W:0]   exp_l[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic se, input logic mi, input logic cl,
                            input logic rdy, input logic rs);
    logic         loaded;
    logic [W-1:0] wm, wl;
    int           ones;
    loaded = 1'b0;
    if (rs) begin
      frame_bits.delete();
      m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
      m_data_m = '0;  m_data_l = '0;
      exp_m.delete(); exp_l.delete();
    end else begin
      if (cl) begin
        frame_bits.delete();
        m_ovr = 1'b0;
      end else if (se) begin
        frame_bits.push_back(mi);
        if (frame_bits.size() == FB) begin
          wm = '0; wl = '0; ones = 0;
          for (int i = 0; i < W; i++) begin
            if (frame_bits[i]) begin
              wm = wm | (W'(1) << (W - 1 - i));
              wl = wl | (W'(1) << i);
            end
          end
          for (int i = 0; i < FB; i++) ones += int'(frame_bits[i]);
          frame_bits.delete();
          if (!m_valid || rdy) begin
            m_data_m = wm; m_data_l = wl;
            m_perr   = (FB > W) ? logic'(ones % 2) : 1'b0;
            m_valid  = 1'b1;
            loaded   = 1'b1;
            exp_m.push_back({m_perr, wm});
            exp_l.push_back({m_perr, wl});
          end else begin
            m_ovr = 1'b1;
          end
        end
      end
      if (m_valid && rdy && !loaded) m_valid = 1'b0;
    end
    m_busy = (frame_bits.size() != 0);
  endtask

  // One clock: drive inputs, advance the model, check flags just after the edge
  task automatic cycle(input logic se, input logic mi, input logic cl,
                       input logic rdy, input logic rs);
    shift_en = se; miso = mi; clr = cl; ready = rdy; rst = rs;
    model_step(se, mi, cl, rdy, rs);
    @(posedge clk);
    #1;
    check("valid_m", if_m.out_valid, m_valid);
    check("valid_l", if_l.out_valid, m_valid);
    check("ovr_m", ovr_m, m_ovr);
    check("ovr_l", ovr_l, m_ovr);
    check("busy_m", busy_m, m_busy);
    check("busy_l", busy_l, m_busy);
  endtask

  // Send a word first-bit = v[7], optional parity bit last; ready only on the final bit
  task automatic send_word(input logic [7:0] v, input logic rdy_last, input logic par);
    for (int i = 0; i < W; i++)
      cycle(1'b1, v[W-1-i], 1'b0, (FB == W && i == W - 1) ? rdy_last : 1'b0, 1'b0);
    if (FB > W) cycle(1'b1, par, 1'b0, rdy_last, 1'b0);
  endtask

  // Scoreboard monitors: a handover happens on the edge after valid && ready is seen
  always @(negedge clk) begin
    if (!rst && if_m.out_valid && if_m.out_ready) begin
      if (exp_m.size() == 0) check("unexpected_word_m", {23'd0, perr_m, if_m.data_out}, 32'hFFFF_FFFF);
      else check("word_m", {23'd0, perr_m, if_m.data_out}, {23'd0, exp_m.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst && if_l.out_valid && if_l.out_ready) begin
      if (exp_l.size() == 0) check("unexpected_word_l", {23'd0, perr_l, if_l.data_out}, 32'hFFFF_FFFF);
      else check("word_l", {23'd0, perr_l, if_l.data_out}, {23'd0, exp_l.pop_front()});
    end
  end

  initial begin
    logic se, mi, cl, rdy, rs;
    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_data_m", if_m.data_out, 8'h00);
    check("rst_data_l", if_l.data_out, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // MSB-first A5; LSB-first sees the palindrome as A5 too
    send_word(8'hA5, 1'b0, ^8'hA5);
    check("t1_valid", if_m.out_valid, 1'b1);
    check("t1_data_m", if_m.data_out, 8'hA5);
    check("t1_data_l", if_l.data_out, 8'hA5);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_drop_valid", if_m.out_valid, 1'b0);

    // Bits 1,1,0,0,0,0,0,0: C0 MSB-first, 03 LSB-first
    send_word(8'hC0, 1'b0, ^8'hC0);
    check("t2_data_m", if_m.data_out, 8'hC0);
    check("t2_data_l", if_l.data_out, 8'h03);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back 3C, C3 unaccepted: C3 dropped, overrun set; clr keeps the word
    send_word(8'h3C, 1'b0, ^8'h3C);
    send_word(8'hC3, 1'b0, ^8'hC3);
    check("t3_ovr", ovr_m, 1'b1);
    check("t3_data_m", if_m.data_out, 8'h3C);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t3_clr_ovr", ovr_m, 1'b0);
    check("t3_clr_data", if_m.data_out, 8'h3C);
    check("t3_clr_valid", if_m.out_valid, 1'b1);

    // 5A completes in the very cycle 3C is accepted
    send_word(8'h5A, 1'b1, ^8'h5A);
    check("t4_valid", if_m.out_valid, 1'b1);
    check("t4_data_m", if_m.data_out, 8'h5A);
    check("t4_ovr", ovr_m, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Partial frame, then clr together with shift_en: the frame restarts cleanly
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_busy_mid", busy_m, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_busy_clr", busy_m, 1'b0);
    send_word(8'hFF, 1'b0, ^8'hFF);
    check("t5_data_m", if_m.data_out, 8'hFF);
    check("t5_data_l", if_l.data_out, 8'hFF);

    // Reset mid-frame with a word pending
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_data", if_m.data_out, 8'h00);
    check("t6_valid", if_m.out_valid, 1'b0);
    check("t6_busy", busy_m, 1'b0);
    check("t6_ovr", ovr_m, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SPI_SIPO_PARITY_EN
    // A5 has even weight, so a parity bit of 1 is an error
    send_word(8'hA5, 1'b0, 1'b1);
    check("t6_perr", perr_m, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized traffic: slow consumer first (overruns), then a fast one
    for (int n = 0; n < 3000; n++) begin
      rs  = ($urandom_range(0, 249) == 0);
      cl  = ($urandom_range(0, 39) == 0);
      se  = ($urandom_range(0, 9) < 7);
      mi  = 1'($urandom);
      rdy = rs ? 1'b0 : (n < 1500 ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8));
      cycle(se, mi, cl, rdy, rs);
    end

    // Drain any pending word and confirm every predicted word was handed over
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("drain_m", exp_m.size(), 0);
    check("drain_l", exp_l.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
